uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arb_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_byte_sequencer.sv | 132 +++++++++++++
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// byte-count width and the MSB-first pre-alignment used when a word is loaded.
package uart_tx_arb_pkg;

    localparam int BYTE_CNT_W = 2;

    typedef logic [1:0] tx_arb_state_t;

    localparam tx_arb_state_t ST_IDLE      = 2'd0;
    localparam tx_arb_state_t ST_ISSUE     = 2'd1;
    localparam tx_arb_state_t ST_WAIT_ACK  = 2'd2;
    localparam tx_arb_state_t ST_WAIT_DONE = 2'd3;

    // Place the first byte to send in [31:24] so MSB-first always emits the top byte.
    function automatic logic [31:0] msb_align(input logic [31:0] data,
                                              input logic [BYTE_CNT_W-1:0] len);
        logic [31:0] res;
        case (len)
            2'd0:    res = {data[7:0], 24'h000000};
            2'd1:    res = {data[15:0], 16'h0000};
            2'd2:    res = {data[23:0], 8'h00};
            2'd3:    res = data;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two requester handshakes and the UartTx side of the arbiter.
interface uart_tx_arbiter_if;
    import uart_tx_arb_pkg::*;

    logic                  req0_valid;
    logic [31:0]           req0_data;
    logic [BYTE_CNT_W-1:0] req0_len;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [31:0]           req1_data;
    logic [BYTE_CNT_W-1:0] req1_len;
    logic                  req1_ready;
    logic                  tx_start;
    logic [7:0]            sdata;
    logic                  tx_busy;
    logic                  active;
    logic                  grant;

    modport slave (
        input  req0_valid, req0_data, req0_len,
        input  req1_valid, req1_data, req1_len,
        input  tx_busy,
        output req0_ready, req1_ready, tx_start, sdata, active, grant
    );

    modport master (
        output req0_valid, req0_data, req0_len,
        output req1_valid, req1_data, req1_len,
        output tx_busy,
        input  req0_ready, req1_ready, tx_start, sdata, active, grant
    );

endinterface

// File: rtl/uart_byte_sequencer.sv
// Serialises one loaded 32-bit word into 1-4 bytes toward UartTx, pacing each
// byte on tx_busy with a timeout in case the busy acknowledge never arrives.
module uart_byte_sequencer
    import uart_tx_arb_pkg::*;
#(
    parameter int LSB_FIRST   = 1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [31:0]           load_data,
    input  logic [BYTE_CNT_W-1:0] load_len,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    output logic                  active,
    output logic                  done
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    tx_arb_state_t         state_q, state_d;
    logic [31:0]           sr_q, sr_d;
    logic [BYTE_CNT_W-1:0] rem_q, rem_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            sdata_q, sdata_d;
    logic                  active_q, active_d;
    logic [7:0]            cur_byte_s;
    logic                  done_s;

    // Next-state, shift register, remaining-byte and ack-timeout logic.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        sdata_d    = sdata_q;
        done_s     = 1'b0;
        if (LSB_FIRST != 0) begin
            cur_byte_s = sr_q[7:0];
        end else begin
            cur_byte_s = sr_q[31:24];
        end
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (LSB_FIRST != 0) begin
                        sr_d = load_data;
                    end else begin
                        sr_d = msb_align(load_data, load_len);
                    end
                    rem_d   = load_len;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    sdata_d    = cur_byte_s;
                    tmo_d      = {TMO_W{1'b0}};
                    state_d    = ST_WAIT_ACK;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_ACK: begin
                // A lost busy acknowledge must not wedge the shared transmitter.
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (rem_q == {BYTE_CNT_W{1'b0}}) begin
                        done_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        state_d = ST_ISSUE;
                        if (LSB_FIRST != 0) begin
                            sr_d = {8'h00, sr_q[31:8]};
                        end else begin
                            sr_d = {sr_q[23:0], 8'h00};
                        end
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        active_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered UartTx-facing outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sr_q       <= 32'h00000000;
            rem_q      <= {BYTE_CNT_W{1'b0}};
            tmo_q      <= {TMO_W{1'b0}};
            tx_start_q <= 1'b0;
            sdata_q    <= 8'h00;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            tx_start_q <= tx_start_d;
            sdata_q    <= sdata_d;
            active_q   <= active_d;
        end
    end

    assign tx_start = tx_start_q;
    assign sdata    = sdata_q;
    assign active   = active_q;
    assign done     = done_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the shared UART transmitter to the DMA controller or the MCH one word
// at a time; byte pacing is delegated to uart_byte_sequencer.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int LSB_FIRST      = 1,
    parameter int FIXED_PRIORITY = 0,
    parameter int ACK_TIMEOUT    = 4
) (
    input  logic        clock,
    input  logic        resetn,
    uart_tx_arbiter_if.slave bus
);

    logic                  winner_s;
    logic                  load_s;
    logic [31:0]           load_data_s;
    logic [BYTE_CNT_W-1:0] load_len_s;
    logic                  seq_done_s;
    logic                  ready0_q, ready0_d;
    logic                  ready1_q, ready1_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  word_busy_q, word_busy_d;

    // Winner selection and grant bookkeeping; a word is never preempted.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            if (FIXED_PRIORITY != 0) begin
                winner_s = 1'b0;
            end else begin
                winner_s = ~last_grant_q;
            end
        end else if (bus.req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        load_s = (bus.req0_valid | bus.req1_valid) & ~word_busy_q;
        if (winner_s) begin
            load_data_s = bus.req1_data;
            load_len_s  = bus.req1_len;
        end else begin
            load_data_s = bus.req0_data;
            load_len_s  = bus.req0_len;
        end
        ready0_d = load_s & ~winner_s;
        ready1_d = load_s & winner_s;
        if (load_s) begin
            grant_d      = winner_s;
            last_grant_d = winner_s;
            word_busy_d  = 1'b1;
        end else if (seq_done_s) begin
            grant_d      = grant_q;
            last_grant_d = last_grant_q;
            word_busy_d  = 1'b0;
        end else begin
            grant_d      = grant_q;
            last_grant_d = last_grant_q;
            word_busy_d  = word_busy_q;
        end
    end

    // Grant registers; last_grant starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            word_busy_q  <= 1'b0;
        end else begin
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_busy_q  <= word_busy_d;
        end
    end

    assign bus.req0_ready = ready0_q;
    assign bus.req1_ready = ready1_q;
    assign bus.grant      = grant_q;

    uart_byte_sequencer #(
        .LSB_FIRST  (LSB_FIRST),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_seq (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load_s),
        .load_data(load_data_s),
        .load_len (load_len_s),
        .tx_busy  (bus.tx_busy),
        .tx_start (bus.tx_start),
        .sdata    (bus.sdata),
        .active   (bus.active),
        .done     (seq_done_s)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed/randomised bench for uart_tx_arbiter: instance A is LSB-first round-robin,
// instance B is MSB-first fixed-priority; a byte-stream model predicts every output.
module tb_uart_tx_arbiter;

    localparam int TMO = 4;

    logic        clock;
    logic        resetn;
    logic        sel;
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic [1:0]  l0, l1;
    logic        busy_en, hold_busy;
    int          busy_len;
    int          cnt_a, cnt_b;
    int          n_checks, n_pass, cyc, ready_cnt;
    logic [7:0]  obs_q[$];
    logic [7:0]  exp_q[$];
    int          ts_cyc[$];
    int          grants[$];
    logic [33:0] pend0[$];
    logic [33:0] pend1[$];
    logic        m_last [2];
    logic        o_r0, o_r1, o_ts, o_act, o_grant;
    logic [7:0]  o_sd;

    uart_tx_arbiter_if ifa();
    uart_tx_arbiter_if ifb();

    uart_tx_arbiter #(.LSB_FIRST(1), .FIXED_PRIORITY(0), .ACK_TIMEOUT(TMO)) dut_a (
        .clock(clock), .resetn(resetn), .bus(ifa)
    );
    uart_tx_arbiter #(.LSB_FIRST(0), .FIXED_PRIORITY(1), .ACK_TIMEOUT(TMO)) dut_b (
        .clock(clock), .resetn(resetn), .bus(ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ifa.req0_valid = v0 & ~sel;
    assign ifa.req1_valid = v1 & ~sel;
    assign ifb.req0_valid = v0 & sel;
    assign ifb.req1_valid = v1 & sel;
    assign ifa.req0_data = d0;
    assign ifa.req1_data = d1;
    assign ifb.req0_data = d0;
    assign ifb.req1_data = d1;
    assign ifa.req0_len = l0;
    assign ifa.req1_len = l1;
    assign ifb.req0_len = l0;
    assign ifb.req1_len = l1;
    assign ifa.tx_busy = (cnt_a != 0) | hold_busy;
    assign ifb.tx_busy = (cnt_b != 0) | hold_busy;

    assign o_r0    = sel ? ifb.req0_ready : ifa.req0_ready;
    assign o_r1    = sel ? ifb.req1_ready : ifa.req1_ready;
    assign o_ts    = sel ? ifb.tx_start   : ifa.tx_start;
    assign o_sd    = sel ? ifb.sdata      : ifa.sdata;
    assign o_act   = sel ? ifb.active     : ifa.active;
    assign o_grant = sel ? ifb.grant      : ifa.grant;

    // UartTx stand-ins: busy for busy_len cycles after seeing a start pulse.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            if (ifa.tx_start && busy_en) cnt_a <= busy_len;
            else if (cnt_a != 0) cnt_a <= cnt_a - 1;
            if (ifb.tx_start && busy_en) cnt_b <= busy_len;
            else if (cnt_b != 0) cnt_b <= cnt_b - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Expected byte stream of one word, from the byte-ordering rule.
    task automatic push_word(input logic [31:0] d, input logic [1:0] l, input logic lsb);
        logic [31:0] w;
        for (int i = 0; i <= int'(l); i++) begin
            if (lsb) w = d >> (8 * i);
            else     w = d >> (8 * (int'(l) - i));
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        ts_cyc.delete();
        grants.delete();
        ready_cnt = 0;
    endtask

    // One cycle: sample outputs at the falling edge and play both requesters.
    task automatic tick();
        logic win;
        @(negedge clock);
        cyc++;
        if (o_ts) begin
            obs_q.push_back(o_sd);
            ts_cyc.push_back(cyc);
        end
        if (o_r0 || o_r1) begin
            ready_cnt++;
            if (v0 && v1) win = sel ? 1'b0 : ~m_last[0];
            else          win = v0 ? 1'b0 : 1'b1;
            chk("winner", {31'd0, o_r1}, {31'd0, win});
            chk("grant_out", {31'd0, o_grant}, {31'd0, win});
            m_last[sel] = win;
            grants.push_back(o_r1 ? 1 : 0);
            if (o_r0) begin
                push_word(d0, l0, ~sel);
                if (pend0.size() > 0) {l0, d0} = pend0.pop_front();
                else v0 = 1'b0;
            end else begin
                push_word(d1, l1, ~sel);
                if (pend1.size() > 0) {l1, d1} = pend1.pop_front();
                else v1 = 1'b0;
            end
        end
    endtask

    task automatic run_words(input string tag, input int max_cyc);
        int k;
        k = 0;
        if (pend0.size() > 0) begin {l0, d0} = pend0.pop_front(); v0 = 1'b1; end
        if (pend1.size() > 0) begin {l1, d1} = pend1.pop_front(); v1 = 1'b1; end
        do begin
            tick();
            k++;
        end while ((v0 || v1 || o_act) && k < max_cyc);
        chk({tag, "_finished"}, {31'd0, (k < max_cyc)}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        clear_obs();
    endtask

    task automatic do_reset();
        v0 = 1'b0;
        v1 = 1'b0;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        m_last[0] = 1'b1;
        m_last[1] = 1'b1;
        tick();
        clear_obs();
    endtask

    initial begin
        int k;
        n_checks = 0; n_pass = 0; cyc = 0; ready_cnt = 0;
        sel = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 32'd0; d1 = 32'd0; l0 = 2'd0; l1 = 2'd0;
        busy_en = 1'b1; hold_busy = 1'b0; busy_len = 20;
        m_last[0] = 1'b1; m_last[1] = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_tx_start", {31'd0, o_ts}, 32'd0);
            chk("rst_sdata", {24'd0, o_sd}, 32'd0);
            chk("rst_ready", {30'd0, o_r1, o_r0}, 32'd0);
            chk("rst_active", {31'd0, o_act}, 32'd0);
            chk("rst_grant", {31'd0, o_grant}, 32'd0);
        end
        sel = 1'b0;
        resetn = 1'b1;
        tick();

        // Single 4-byte word, UartTx busy for 20 cycles per byte.
        pend0.push_back({2'd3, 32'h44332211});
        run_words("single", 300);
        chk("single_nstarts", obs_q.size(), 32'd4);
        chk("single_ready", ready_cnt, 32'd1);
        for (int i = 1; i < ts_cyc.size(); i++)
            chk("single_gap", ts_cyc[i] - ts_cyc[i-1], busy_len + 3);
        check_stream("single");

        // Round-robin ties with random words: order must alternate 0,1,0,1,...
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 3; i++) begin
            pend0.push_back({2'($urandom_range(3, 0)), 32'($urandom)});
            pend1.push_back({2'($urandom_range(3, 0)), 32'($urandom)});
        end
        run_words("rr", 600);
        chk("rr_ngrants", grants.size(), 32'd6);
        for (int i = 0; i < grants.size(); i++)
            chk("rr_order", grants[i], i % 2);
        check_stream("rr");

        // Lost acknowledge: tx_busy never rises, timeout paces the bytes.
        busy_en = 1'b0;
        pend1.push_back({2'd2, 32'($urandom)});
        run_words("lost", 200);
        chk("lost_nstarts", obs_q.size(), 32'd3);
        for (int i = 1; i < ts_cyc.size(); i++)
            chk("lost_gap", ts_cyc[i] - ts_cyc[i-1], TMO + 2);
        chk("lost_idle", {31'd0, o_act}, 32'd0);
        check_stream("lost");
        busy_en = 1'b1;

        // tx_busy already high when the word is granted: start is held off.
        hold_busy = 1'b1;
        d0 = 32'($urandom); l0 = 2'd1; v0 = 1'b1;
        repeat (10) tick();
        chk("held_nstarts", obs_q.size(), 32'd0);
        chk("held_active", {31'd0, o_act}, 32'd1);
        hold_busy = 1'b0;
        run_words("held", 200);
        check_stream("held");

        // Reset during the third byte's start pulse of a 4-byte word.
        busy_len = 5;
        d0 = 32'($urandom); l0 = 2'd3; v0 = 1'b1;
        k = 0;
        while (obs_q.size() < 3 && k < 200) begin
            tick();
            k++;
        end
        chk("mid_reached", {31'd0, (k < 200)}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_tx_start", {31'd0, o_ts}, 32'd0);
        chk("mid_active", {31'd0, o_act}, 32'd0);
        chk("mid_grant", {31'd0, o_grant}, 32'd0);
        tick();
        resetn = 1'b1;
        m_last[0] = 1'b1;
        m_last[1] = 1'b1;
        clear_obs();
        repeat (5) tick();
        chk("mid_no_ready", ready_cnt, 32'd0);
        chk("mid_no_start", obs_q.size(), 32'd0);
        pend1.push_back({2'd1, 32'($urandom)});
        run_words("after_rst", 200);
        check_stream("after_rst");

        // Instance B: MSB-first byte order, then fixed priority under contention.
        sel = 1'b1;
        busy_len = 3;
        pend0.push_back({2'd1, 32'h0000A1B2});
        run_words("msb", 200);
        if (obs_q.size() >= 2) begin
            chk("msb_first", {24'd0, obs_q[0]}, 32'h000000A1);
            chk("msb_second", {24'd0, obs_q[1]}, 32'h000000B2);
        end
        check_stream("msb");
        for (int i = 0; i < 3; i++) pend0.push_back({2'($urandom_range(3, 0)), 32'($urandom)});
        for (int i = 0; i < 2; i++) pend1.push_back({2'($urandom_range(3, 0)), 32'($urandom)});
        run_words("fixed", 600);
        chk("fixed_ngrants", grants.size(), 32'd5);
        for (int i = 0; i < grants.size(); i++)
            chk("fixed_order", grants[i], (i < 3) ? 0 : 1);
        check_stream("fixed");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
